serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor.sv | 135 +++++++++++++
 tb/tb_serial_subtractor.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b - borrow_in, one bit per clock, LSB first.
// Operands enter on a valid/ready handshake in IDLE; the result is held in DONE until consumed.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             in_clk,
  input  logic             in_reset,
  input  logic             in_valid,
  output logic             out_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_borrow,
  output logic             out_valid,
  input  logic             in_ready,
  output logic [WIDTH-1:0] out_diff,
  output logic             out_borrow,
  output logic             out_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_next_s;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] res_r;
  logic [WIDTH-1:0] res_next_s;
  logic             br_r;
  logic             br_next_s;
  logic             d_s;
  logic             last_bit_s;
  logic [CW-1:0]    cnt_r;
  logic             out_ready_r;
  logic             out_valid_r;
  logic [WIDTH-1:0] diff_r;
  logic             borrow_r;
  logic             zero_r;

  // One step of the borrow chain on the current operand LSBs
  always_comb begin
    d_s        = a_r[0] ^ b_r[0] ^ br_r;
    br_next_s  = (~a_r[0] & b_r[0]) | (~(a_r[0] ^ b_r[0]) & br_r);
    res_next_s = res_r >> 1'b1;
    res_next_s[WIDTH-1] = d_s;
    last_bit_s = (cnt_r == CW'(WIDTH - 1));
  end

  // Next-state decode
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) state_next_s = RUN;
        else          state_next_s = IDLE;
      end
      RUN: begin
        if (last_bit_s) state_next_s = DONE;
        else            state_next_s = RUN;
      end
      DONE: begin
        if (in_ready) state_next_s = IDLE;
        else          state_next_s = DONE;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State register with handshake outputs registered from the next state
  always_ff @(posedge in_clk) begin
    if (in_reset) begin
      state_r     <= IDLE;
      out_ready_r <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      out_ready_r <= (state_next_s == IDLE);
      out_valid_r <= (state_next_s == DONE);
    end
  end

  // Operand shifters, borrow flop, bit counter and result registers
  always_ff @(posedge in_clk) begin
    if (in_reset) begin
      a_r      <= {WIDTH{1'b0}};
      b_r      <= {WIDTH{1'b0}};
      res_r    <= {WIDTH{1'b0}};
      br_r     <= 1'b0;
      cnt_r    <= {CW{1'b0}};
      diff_r   <= {WIDTH{1'b0}};
      borrow_r <= 1'b0;
      zero_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            a_r   <= in_a;
            b_r   <= in_b;
            br_r  <= in_borrow;
            cnt_r <= {CW{1'b0}};
          end
        end
        RUN: begin
          a_r   <= a_r >> 1'b1;
          b_r   <= b_r >> 1'b1;
          br_r  <= br_next_s;
          res_r <= res_next_s;
          cnt_r <= cnt_r + CW'(1);
          // Final bit: publish the completed result in the same edge as entering DONE
          if (last_bit_s) begin
            diff_r   <= res_next_s;
            borrow_r <= br_next_s;
            zero_r   <= (res_next_s == {WIDTH{1'b0}});
          end
        end
        DONE: begin
        end
        default: begin
        end
      endcase
    end
  end

  assign out_ready  = out_ready_r;
  assign out_valid  = out_valid_r;
  assign out_diff   = diff_r;
  assign out_borrow = borrow_r;
  assign out_zero   = zero_r;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: directed WIDTH=8 cases, backpressure, mid-run reset,
// and random operands on WIDTH=1 and WIDTH=32 instances against an arithmetic reference.
module tb_serial_subtractor;

  typedef struct {
    logic [31:0] diff;
    logic        bo;
    logic        z;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  vld;
  logic [2:0]  rdy;
  logic [31:0] a_s;
  logic [31:0] b_s;
  logic        bi_s;
  logic [2:0]  ov;
  logic [2:0]  ordy;
  logic [2:0]  obo;
  logic [2:0]  oz;
  logic [7:0]  d8;
  logic [0:0]  d1;
  logic [31:0] d32;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) u_w8 (
    .in_clk(clk), .in_reset(rst), .in_valid(vld[0]), .out_ready(ordy[0]),
    .in_a(a_s[7:0]), .in_b(b_s[7:0]), .in_borrow(bi_s), .out_valid(ov[0]),
    .in_ready(rdy[0]), .out_diff(d8), .out_borrow(obo[0]), .out_zero(oz[0])
  );

  serial_subtractor #(.WIDTH(1)) u_w1 (
    .in_clk(clk), .in_reset(rst), .in_valid(vld[1]), .out_ready(ordy[1]),
    .in_a(a_s[0:0]), .in_b(b_s[0:0]), .in_borrow(bi_s), .out_valid(ov[1]),
    .in_ready(rdy[1]), .out_diff(d1), .out_borrow(obo[1]), .out_zero(oz[1])
  );

  serial_subtractor #(.WIDTH(32)) u_w32 (
    .in_clk(clk), .in_reset(rst), .in_valid(vld[2]), .out_ready(ordy[2]),
    .in_a(a_s), .in_b(b_s), .in_borrow(bi_s), .out_valid(ov[2]),
    .in_ready(rdy[2]), .out_diff(d32), .out_borrow(obo[2]), .out_zero(oz[2])
  );

  function automatic int wid(int k);
    case (k)
      0:       return 8;
      1:       return 1;
      default: return 32;
    endcase
  endfunction

  function automatic logic [31:0] get_diff(int k);
    case (k)
      0:       return {24'd0, d8};
      1:       return {31'd0, d1};
      default: return d32;
    endcase
  endfunction

  function automatic exp_t model(int k, logic [31:0] a, logic [31:0] b, logic bi);
    exp_t        e;
    logic [32:0] mask;
    logic [32:0] aa;
    logic [32:0] bb;
    logic [32:0] t;
    mask   = (33'd1 << wid(k)) - 33'd1;
    aa     = {1'b0, a} & mask;
    bb     = {1'b0, b} & mask;
    t      = aa - bb - {32'd0, bi};
    e.diff = t[31:0] & mask[31:0];
    e.bo   = (aa < bb + {32'd0, bi});
    e.z    = (e.diff == 32'd0);
    return e;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One operation on instance k; hold > 0 keeps in_ready low for that many DONE cycles
  task automatic op(int k, logic [31:0] a, logic [31:0] b, logic bi, int hold);
    int   lat;
    exp_t e;
    lat = 0;
    while (!ordy[k] && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    check("accept_ready", {31'd0, ordy[k]}, 32'd1);
    a_s = a; b_s = b; bi_s = bi;
    vld[k] = 1'b1;
    rdy[k] = (hold == 0);
    @(posedge clk); #1;
    vld[k] = 1'b0;
    sb_q.push_back(model(k, a, b, bi));
    a_s = $urandom; b_s = $urandom; bi_s = ~bi;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!ov[k] && lat < 100);
    check("latency", lat, wid(k));
    check("busy_ready", {31'd0, ordy[k]}, 32'd0);
    e = sb_q.pop_front();
    check("diff", get_diff(k), e.diff);
    check("borrow", {31'd0, obo[k]}, {31'd0, e.bo});
    check("zero", {31'd0, oz[k]}, {31'd0, e.z});
    for (int i = 0; i < hold; i++) begin
      vld[k] = ~vld[k];
      a_s = a_s + 32'd1;
      @(posedge clk); #1;
      check("hold_valid", {31'd0, ov[k]}, 32'd1);
      check("hold_ready", {31'd0, ordy[k]}, 32'd0);
      check("hold_diff", get_diff(k), e.diff);
    end
    vld[k] = 1'b0;
    rdy[k] = 1'b1;
    @(posedge clk); #1;
    check("consumed_valid", {31'd0, ov[k]}, 32'd0);
    check("consumed_ready", {31'd0, ordy[k]}, 32'd1);
    check("consumed_diff", get_diff(k), e.diff);
    rdy[k] = 1'b0;
  endtask

  initial begin
    rst = 1'b1; vld = 3'b000; rdy = 3'b000;
    a_s = 32'd0; b_s = 32'd0; bi_s = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      check("rst_valid", {31'd0, ov[k]}, 32'd0);
      check("rst_ready", {31'd0, ordy[k]}, 32'd1);
      check("rst_diff", get_diff(k), 32'd0);
      check("rst_borrow", {31'd0, obo[k]}, 32'd0);
      check("rst_zero", {31'd0, oz[k]}, 32'd0);
    end

    op(0, 32'h5A, 32'h3C, 1'b0, 0);
    op(0, 32'h10, 32'h20, 1'b0, 0);
    op(0, 32'h77, 32'h77, 1'b0, 0);
    op(0, 32'h00, 32'h00, 1'b1, 0);
    op(0, 32'hFF, 32'h00, 1'b1, 0);
    op(0, 32'hC3, 32'h81, 1'b0, 5);

    // Abandon an operation with reset sampled on the edge that would process bit 3
    a_s = 32'h5A; b_s = 32'h3C; bi_s = 1'b0;
    vld[0] = 1'b1;
    @(posedge clk); #1;
    vld[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_valid", {31'd0, ov[0]}, 32'd0);
    check("midrst_ready", {31'd0, ordy[0]}, 32'd1);
    check("midrst_diff", get_diff(0), 32'd0);
    op(0, 32'h05, 32'h03, 1'b0, 0);

    for (int i = 0; i < 1000; i++) op(1, $urandom, $urandom, 1'($urandom_range(0, 1)), 0);
    for (int i = 0; i < 1000; i++) op(2, $urandom, $urandom, 1'($urandom_range(0, 1)), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
